// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared types and helpers for the RV32I instruction-fetch stage.
//   fetch_state_t : fetch FSM states
//   ZERO_WORD     : reset value for 32-bit datapath registers
//   align_pc()    : clears the byte-offset bits of a redirect target
// Optional feature macro: ICACHE_EN (see if_fetch.sv).
package if_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } fetch_state_t;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// if_fetch_icache: direct-mapped instruction cache, one 32-bit word per line.
// Only compiled when ICACHE_EN is defined.
//   clk, rst        clock / async active-low reset (clears valid bits only)
//   lookup_addr     word address (pc[31:2]) probed combinationally
//   hit, hit_word   lookup result
//   fill_en         write fill_word into the line selected by fill_addr
//   fill_addr       word address (pc[31:2]) of the filled instruction
//   fill_word       assembled instruction
`ifdef ICACHE_EN
module if_fetch_icache #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_addr,
    output logic        hit,
    output logic [31:0] hit_word,
    input  logic        fill_en,
    input  logic [29:0] fill_addr,
    input  logic [31:0] fill_word
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tags  [LINES];
    logic [31:0]       words [LINES];

    logic [IW-1:0] lk_idx, fl_idx;
    assign lk_idx = lookup_addr[IW-1:0];
    assign fl_idx = fill_addr[IW-1:0];

    assign hit      = valid[lk_idx] && (tags[lk_idx] == lookup_addr[29:IW]);
    assign hit_word = words[lk_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid <= '0;
        else if (fill_en) valid[fl_idx] <= 1'b1;
    end

    // Tag/data storage needs no reset: a line is ignored until its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fl_idx]  <= fill_addr[29:IW];
            words[fl_idx] <= fill_word;
        end
    end
endmodule
`endif

// File: rtl/if_fetch.sv
// if_fetch: RV32I fetch stage. Builds each 32-bit little-endian instruction
// from four single-byte reads and holds it until decode accepts it.
// Optional feature macro: ICACHE_EN enables a direct-mapped I-cache
// (ICACHE_LINES lines); without it every fetch goes to memory.
// Ports:
//   clk, rst                 clock / async active-low reset
//   stall_i                  downstream not accepting this cycle
//   flush_i, flush_target_i  redirect fetch (target word-aligned here)
//   mem_req_o, mem_addr_o    byte read request / address
//   mem_gnt_i, mem_rdata_i   grant; data returns the cycle after the grant
//   pc_o, inst_o             fetched instruction and its PC
//   inst_valid_o             pc_o/inst_o valid; transfer on valid && !stall_i
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);
    if ((ICACHE_LINES < 1) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_chk
        $error("ICACHE_LINES must be a power of 2");
    end

    fetch_state_t state;
    logic [31:0]  pc;
    logic [1:0]   cnt;      // bytes granted so far for this instruction
    logic [1:0]   lane_d;   // lane of the byte returning this cycle
    logic         gnt_d;    // a byte returns this cycle
    logic         drop;     // returning byte was granted in a flush cycle
    logic         valid_q;
    logic         enter_req;
    logic [31:0]  req_pc;
    logic         cache_hit;

    // Every path into S_REQ funnels through here so the cache can be probed
    // with the PC that is about to be fetched.
    always_comb begin
        enter_req = 1'b0;
        req_pc    = pc;
        if (flush_i) begin
            enter_req = 1'b1;
            req_pc    = align_pc(flush_target_i);
        end else if (state == S_IDLE) begin
            enter_req = 1'b1;
        end else if (state == S_VALID && !stall_i) begin
            enter_req = 1'b1;
            req_pc    = pc + 32'd4;
        end
    end

`ifdef ICACHE_EN
    logic        hit_q;
    logic [31:0] cache_word, hit_word_q;

    if_fetch_icache #(.LINES(ICACHE_LINES)) u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (req_pc[31:2]),
        .hit         (cache_hit),
        .hit_word    (cache_word),
        .fill_en     (state == S_WAIT && !flush_i),
        .fill_addr   (pc[31:2]),
        .fill_word   ({mem_rdata_i, inst_o[23:0]})
    );
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            cnt        <= 2'd0;
            lane_d     <= 2'd0;
            gnt_d      <= 1'b0;
            drop       <= 1'b0;
            valid_q    <= 1'b0;
            inst_o     <= ZERO_WORD;
            mem_req_o  <= 1'b0;
            mem_addr_o <= ZERO_WORD;
`ifdef ICACHE_EN
            hit_q      <= 1'b0;
            hit_word_q <= ZERO_WORD;
`endif
        end else begin
            gnt_d  <= mem_req_o && mem_gnt_i;
            lane_d <= cnt;
            drop   <= flush_i && mem_req_o && mem_gnt_i;
            if (gnt_d && !drop) inst_o[{lane_d, 3'b000} +: 8] <= mem_rdata_i;

            if (enter_req) begin
                state      <= S_REQ;
                pc         <= req_pc;
                cnt        <= 2'd0;
                valid_q    <= 1'b0;
                mem_req_o  <= !cache_hit;
                mem_addr_o <= req_pc;
`ifdef ICACHE_EN
                hit_q      <= cache_hit;
                hit_word_q <= cache_word;
`endif
            end else begin
                case (state)
                    S_REQ: begin
`ifdef ICACHE_EN
                        if (hit_q) begin
                            hit_q   <= 1'b0;
                            inst_o  <= hit_word_q;
                            valid_q <= 1'b1;
                            state   <= S_VALID;
                        end else
`endif
                        if (mem_req_o && mem_gnt_i) begin
                            cnt <= cnt + 2'd1;
                            if (cnt == 2'd3) begin
                                mem_req_o <= 1'b0;
                                state     <= S_WAIT;
                            end else begin
                                mem_addr_o <= pc + {30'd0, cnt + 2'd1};
                            end
                        end
                    end
                    S_WAIT: begin
                        // byte 3 lands this cycle via the capture above
                        valid_q <= 1'b1;
                        state   <= S_VALID;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pc_o         = pc;
    assign inst_valid_o = valid_q && !flush_i;

endmodule
